// File: rtl/ttt_referee.sv
// Tic-tac-toe turn controller and judge: validates moves, strobes the square array,
// then scores all eight lines for win, draw or square-array fault.
module ttt_referee (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [3:0] move_sq,
  output logic       move_ready,
  input  logic [8:0] marked,
  input  logic [8:0] owner,
  input  logic [8:0] error,
  output logic [8:0] mark,
  output logic       player,
  output logic       move_reject,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [7:0] win_line,
  output logic [3:0] move_count,
  output logic       fault
);

  typedef enum logic [1:0] {StIdle, StIssue, StCheck, StDone} state_e;

  state_e     state_q, state_d;
  logic [8:0] mark_q, mark_d;
  logic       player_q, player_d;
  logic       reject_q, reject_d;
  logic       over_q, over_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] win_line_q, win_line_d;
  logic [3:0] count_q, count_d;
  logic       fault_q, fault_d;

  logic        handshake;
  logic [15:0] req_onehot;
  logic        req_ok;
  logic [8:0]  mine;
  logic [7:0]  win_hit;

  // Square masks for rows 0-2, cols 0-2, diagonal, anti-diagonal.
  function automatic logic [8:0] line_mask(input logic [2:0] k);
    logic [8:0] m;
    unique case (k)
      3'd0: m = 9'b000_000_111;
      3'd1: m = 9'b000_111_000;
      3'd2: m = 9'b111_000_000;
      3'd3: m = 9'b001_001_001;
      3'd4: m = 9'b010_010_010;
      3'd5: m = 9'b100_100_100;
      3'd6: m = 9'b100_010_001;
      3'd7: m = 9'b001_010_100;
      default: m = 9'b0;
    endcase
    return m;
  endfunction

  assign move_ready = (state_q == StIdle) && !rst;
  assign handshake  = move_valid && move_ready;
  assign req_onehot = 16'd1 << move_sq;
  assign req_ok     = (move_sq < 4'd9) && ((req_onehot[8:0] & marked) == 9'b0);

  // Squares held by the player whose move is being judged.
  assign mine = marked & (player_q ? owner : ~owner);

  always_comb begin
    win_hit = 8'b0;
    for (int k = 0; k < 8; k++) begin
      win_hit[k] = (mine & line_mask(3'(k))) == line_mask(3'(k));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (handshake && req_ok) begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StCheck;
      StCheck: begin
        if ((win_hit != 8'b0) || (count_q == 4'd9)) begin
          state_d = StDone;
        end else begin
          state_d = StIdle;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    mark_d     = 9'b0;
    reject_d   = 1'b0;
    player_d   = player_q;
    over_d     = over_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    count_d    = count_q;
    fault_d    = fault_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          if (req_ok) begin
            mark_d = req_onehot[8:0];
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StIssue: count_d = count_q + 4'd1;
      StCheck: begin
        win_line_d = win_hit;
        if (error != 9'b0) begin
          fault_d = 1'b1;
        end
        if (win_hit != 8'b0) begin
          winner_d = {player_q, ~player_q};
          over_d   = 1'b1;
        end else if (count_q == 4'd9) begin
          winner_d = 2'b11;
          over_d   = 1'b1;
        end else begin
          player_d = ~player_q;
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mark_q     <= 9'b0;
      player_q   <= 1'b0;
      reject_q   <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= 2'b00;
      win_line_q <= 8'b0;
      count_q    <= 4'd0;
      fault_q    <= 1'b0;
    end else begin
      mark_q     <= mark_d;
      player_q   <= player_d;
      reject_q   <= reject_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  assign mark        = mark_q;
  assign player      = player_q;
  assign move_reject = reject_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign win_line    = win_line_q;
  assign move_count  = count_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ttt_referee.sv
// Scoreboard bench for ttt_referee: a board-level game model predicts every mark strobe,
// reject pulse and post-move result; a monitor compares them as the DUT produces them.
module tb_ttt_referee;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_valid = 1'b0;
  logic [3:0] move_sq = 4'd0;
  logic       move_ready;
  logic [8:0] marked, owner, error;
  logic [8:0] mark;
  logic       player, move_reject, game_over, fault;
  logic [1:0] winner;
  logic [7:0] win_line;
  logic [3:0] move_count;
  bit         err_en = 1'b0;

  always #5 clk = ~clk;

  ttt_referee dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_sq    (move_sq),
    .move_ready (move_ready),
    .marked     (marked),
    .owner      (owner),
    .error      (error),
    .mark       (mark),
    .player     (player),
    .move_reject(move_reject),
    .game_over  (game_over),
    .winner     (winner),
    .win_line   (win_line),
    .move_count (move_count),
    .fault      (fault)
  );

  // Behavioural square array: captures mark at the end of the strobe cycle.
  logic [8:0] sa_marked, sa_owner;
  always @(posedge clk) begin
    if (rst) begin
      sa_marked <= 9'b0;
      sa_owner  <= 9'b0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (mark[i]) begin
          sa_marked[i] <= 1'b1;
          sa_owner[i]  <= player;
        end
      end
    end
  end
  assign marked = sa_marked;
  assign owner  = sa_owner;
  assign error  = err_en ? 9'h004 : 9'h000;

  // kind 0: mark (a=mask, b=player); 1: reject (a=player, b=count);
  // 2: result (a=winner, b=win_line, c=game_over, d=count, e=fault, f=player)
  typedef struct {
    int kind;
    int a, b, c, d, e, f;
  } exp_t;
  exp_t q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  bit mon_en = 1'b1;
  int res_cnt = 0;

  int board[9];
  int m_player, m_count, m_over, m_winner, m_wl, m_fault;
  int seq[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic pop_chk(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    if (q.size() == 0) begin
      chk("unexpected_output", kind, -1);
    end else begin
      e = q.pop_front();
      chk("output_order", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst || !mon_en) begin
      res_cnt = 0;
    end else begin
      if (res_cnt > 0) begin
        res_cnt--;
        if (res_cnt == 0) begin
          pop_chk(2, e, ok);
          if (ok) begin
            chk("winner", winner, e.a);
            chk("win_line", win_line, e.b);
            chk("game_over", game_over, e.c);
            chk("move_count", move_count, e.d);
            chk("fault", fault, e.e);
            chk("player_after", player, e.f);
          end
        end
      end
      if (mark != 9'b0) begin
        pop_chk(0, e, ok);
        if (ok) begin
          chk("mark", mark, e.a);
          chk("mark_player", player, e.b);
        end
        res_cnt = 2;
      end
      if (move_reject) begin
        pop_chk(1, e, ok);
        if (ok) begin
          chk("reject_player", player, e.a);
          chk("reject_count", move_count, e.b);
        end
      end
    end
  end

  function automatic int lines_won(input int p);
    int r = 0;
    for (int i = 0; i < 3; i++) begin
      if (board[3*i] == p && board[3*i+1] == p && board[3*i+2] == p) r |= 1 << i;
      if (board[i] == p && board[i+3] == p && board[i+6] == p) r |= 1 << (3 + i);
    end
    if (board[0] == p && board[4] == p && board[8] == p) r |= 1 << 6;
    if (board[2] == p && board[4] == p && board[6] == p) r |= 1 << 7;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) board[i] = -1;
    m_player = 0; m_count = 0; m_over = 0; m_winner = 0; m_wl = 0; m_fault = 0;
  endtask

  task automatic model_step(input int sq, output bit accepted);
    int wl;
    if (sq > 8 || board[sq] != -1) begin
      q.push_back('{1, m_player, m_count, 0, 0, 0, 0});
      accepted = 1'b0;
    end else begin
      accepted = 1'b1;
      q.push_back('{0, 1 << sq, m_player, 0, 0, 0, 0});
      board[sq] = m_player;
      m_count++;
      if (err_en) m_fault = 1;
      wl = lines_won(m_player);
      if (wl != 0) begin
        m_winner = (m_player == 0) ? 1 : 2;
        m_wl = wl;
        m_over = 1;
      end else if (m_count == 9) begin
        m_winner = 3;
        m_over = 1;
      end else begin
        m_player ^= 1;
      end
      q.push_back('{2, m_winner, m_wl, m_over, m_count, m_fault, m_player});
    end
  endtask

  task automatic do_move(input int sq);
    int  b = 0;
    bit  acc;
    while (!move_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("move_ready_before_move", move_ready, 1);
    if (!move_ready) return;
    move_valid = 1'b1;
    move_sq = 4'(sq);
    model_step(sq, acc);
    @(posedge clk);
    #1 move_valid = 1'b0;
    if (acc) repeat (3) @(negedge clk);
    else @(negedge clk);
    #1 err_en = 1'b0;
  endtask

  task automatic play_seq();
    foreach (seq[i]) do_move(seq[i]);
  endtask

  task automatic reset_dut();
    move_valid = 1'b0;
    err_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", move_ready, 0);
    chk("rst_mark", mark, 0);
    chk("rst_player", player, 0);
    chk("rst_reject", move_reject, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    chk("rst_win_line", win_line, 0);
    chk("rst_move_count", move_count, 0);
    chk("rst_fault", fault, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    model_reset();
    rst = 1'b0;
    #1 chk("ready_after_rst", move_ready, 1);
  endtask

  task automatic done_pulses();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      move_valid = 1'b1;
      move_sq = 4'($urandom_range(0, 8));
      @(posedge clk);
      #1;
      chk("done_mark", mark, 0);
      chk("done_reject", move_reject, 0);
      chk("done_ready", move_ready, 0);
      chk("done_game_over", game_over, 1);
    end
    move_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    model_reset();
    reset_dut();

    // Row 0 win by player 0, then requests in DONE are ignored.
    seq = '{0, 3, 1, 4, 2};
    play_seq();
    if (m_over != 0) done_pulses();

    // Occupied and out-of-range squares.
    reset_dut();
    seq = '{4, 4, 9, 15, 0};
    play_seq();

    // Full-board draw, then a ninth-move win.
    reset_dut();
    seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    play_seq();
    reset_dut();
    seq = '{0, 1, 2, 4, 3, 5, 7, 8, 6};
    play_seq();

    // Reset while the mark strobe is out.
    reset_dut();
    do_move(0);
    mon_en = 1'b0;
    move_valid = 1'b1;
    move_sq = 4'd4;
    @(posedge clk);
    #1 move_valid = 1'b0;
    rst = 1'b1;
    chk("issue_mark", mark, 9'h010);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_issue_mark", mark, 0);
    chk("rst_issue_count", move_count, 0);
    chk("rst_issue_player", player, 0);
    chk("rst_issue_ready", move_ready, 1);
    q.delete();
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;

    // Square-array error seen in CHECK: fault sticks, play continues.
    err_en = 1'b1;
    do_move(4);
    seq = '{0, 1, 8};
    play_seq();

    // Randomised games with occasional illegal requests and error injection.
    for (int g = 0; g < 12; g++) begin
      reset_dut();
      for (int n = 0; n < 40 && m_over == 0; n++) begin
        err_en = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 3) == 0) do_move($urandom_range(0, 15));
        else do_move($urandom_range(0, 8));
      end
      if (m_over != 0) done_pulses();
    end

    repeat (5) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
